// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: turns hazard, mispredict and halt requests into per-stage
// write/flush enables and sequences warm-up, branch squash and halt drain.
module pipe_seq_ctrl #(
    parameter int WARMUP_CYCLES = 3,
    parameter int FLUSH_CYCLES  = 2,
    parameter int DRAIN_CYCLES  = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             mispredict,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int M1   = (WARMUP_CYCLES > FLUSH_CYCLES) ? WARMUP_CYCLES : FLUSH_CYCLES;
    localparam int MAXC = (M1 > DRAIN_CYCLES) ? M1 : DRAIN_CYCLES;
    localparam int SW   = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t        cur;
    logic [SW-1:0] seq_cnt;

    assign state = cur;

    // One shared down-counter serves warm-up, squash and drain, since only one is live at a time
    always_ff @(posedge clock) begin
        if (reset) begin
            cur       <= WARMUP;
            seq_cnt   <= SW'(WARMUP_CYCLES);
            stall_cnt <= '0;
            flush_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            case (cur)
                WARMUP: begin
                    if (seq_cnt <= SW'(1)) begin
                        cur     <= RUN;
                        seq_cnt <= '0;
                    end else begin
                        seq_cnt <= seq_cnt - SW'(1);
                    end
                end
                RUN: begin
                    if (mispredict) begin
                        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
                        if (FLUSH_CYCLES > 1) begin
                            cur     <= FLUSH;
                            seq_cnt <= SW'(FLUSH_CYCLES - 1);
                        end
                    end else if (stall_req) begin
                        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
                    end else if (halt_req) begin
                        cur     <= HALT;
                        seq_cnt <= SW'(DRAIN_CYCLES);
                    end
                end
                FLUSH: begin
                    if (seq_cnt <= SW'(1)) begin
                        cur     <= RUN;
                        seq_cnt <= '0;
                    end else begin
                        seq_cnt <= seq_cnt - SW'(1);
                    end
                end
                HALT: begin
                    if (seq_cnt != '0) begin
                        seq_cnt <= seq_cnt - SW'(1);
                        if (seq_cnt == SW'(1)) halted <= 1'b1;
                    end
                end
                default: cur <= WARMUP;
            endcase
        end
    end

    // Enables default to the warm-up bubble pattern, which reset also forces
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_we   = 1'b1;
        if (!reset) begin
            case (cur)
                RUN: begin
                    if (mispredict) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                    end else if (stall_req || halt_req) begin
                        ifid_flush = 1'b0;
                    end else begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                FLUSH: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
